flash_sample_reader: RTL and testbench
======================================

Name: flash_sample_reader

Overview:
- Producer end of the sample-hand-off interface between flash and the audio path.
- Fetches 32-bit words from the flash Avalon-MM read port and splits each word into two 16-bit samples.
- Presents one sample at a time on getdata and advances only when the downstream consumer pulses confirm_pass.
- Supports forward/backward playback and restart from PS/2 scan codes on key_control.

Parameters:
- ADDR_W, 23, flash word-address width.
- START_ADDR, 23'h000000, first word address of the sample region.
- END_ADDR, 23'h07FFFF, last word address of the sample region (inclusive).

Ports:
- clock50  input  1  system clock, 50 MHz.
- rstn  input  1  synchronous reset, active-high (asserted = 1), sampled on posedge clock50.
- key_control  input  8  PS/2 scan code of the last key: 8'h2B F = forward, 8'h32 B = backward, 8'h2D R = restart.
- confirm_pass  input  1  one-cycle pulse from the consumer: the current getdata has been taken.
- getdata  output  16  current sample, held stable until consumed.
- data_valid  output  1  high while getdata holds an unconsumed sample.
- flash_mem_read  output  1  Avalon read request.
- flash_mem_address  output  ADDR_W  word address.
- flash_mem_byteenable  output  4  constant 4'hF.
- flash_mem_waitrequest  input  1  slave stall.
- flash_mem_readdata  input  32  read data.
- flash_mem_readdatavalid  input  1  read data qualifier.

Behaviour:
- Reset values:
  - getdata = 0, data_valid = 0, flash_mem_read = 0, flash_mem_address = START_ADDR.
  - Direction = forward; restart_pending = 0; word register = 0.
  - State = REQ.
- Reset is synchronous and overrides everything, including mid-read. flash_mem_read drops at the reset edge. A readdatavalid arriving while reset is asserted, or in the first cycle after reset, is ignored.
- Direction register:
  - Set forward on key_control == 8'h2B, backward on 8'h32, evaluated every cycle.
  - Other codes leave it unchanged.
- Restart:
  - restart_pending sets on the cycle key_control transitions to 8'h2D from any other value (edge, not level). A held R restarts once.
  - Cleared in ADVANCE.
- State REQ:
  - Drive flash_mem_read = 1 with flash_mem_address stable.
  - On a rising edge where waitrequest == 0: flash_mem_read <= 0, go to WAIT_DATA.
  - While waitrequest == 1: hold read and address.
- State WAIT_DATA:
  - On readdatavalid: capture readdata and latch word_dir = current direction.
  - getdata <= forward ? readdata[15:0] : readdata[31:16]; data_valid <= 1.
  - Go to FIRST.
  - Minimum latency from read accept to data_valid high: 1 cycle after readdatavalid.
- State FIRST:
  - On confirm_pass: getdata <= other half (word_dir forward ? [31:16] : [15:0]); data_valid stays 1; go to SECOND.
  - The new half is visible the cycle after the pulse.
- State SECOND:
  - On confirm_pass: data_valid <= 0, go to ADVANCE.
- State ADVANCE (1 cycle), address update:
  - If restart_pending: address <= forward ? START_ADDR : END_ADDR.
  - Else forward: address == END_ADDR ? START_ADDR : +1.
  - Else backward: address == START_ADDR ? END_ADDR : −1.
  - Clear restart_pending; go to REQ.
  - Direction used here is the current direction register, not word_dir.
- confirm_pass handling:
  - Ignored in REQ, WAIT_DATA and ADVANCE.
  - A pulse longer than one cycle counts once per state (consumed state change only).
- Direction change mid-word: does not reorder the halves of the word already captured. It takes effect at the next ADVANCE.
- Address arithmetic is ADDR_W-bit unsigned; wrap only at the region bounds, never at 2^ADDR_W.
- Throughput: two samples per flash read. Flash latency must be shorter than one sample period (22 kHz consumer) for gap-free audio. No buffering beyond one word.

Test Plan:
- Forward basics:
  - Stimulus: reset, flash returns 32'hBBBB_AAAA at addr 0 and 32'hDDDD_CCCC at addr 1; four confirm_pass pulses.
  - Response: getdata sequence AAAA, BBBB, CCCC, DDDD; addresses 0, 1, 2 requested; data_valid low in the ADVANCE/REQ gaps.
- Waitrequest stall:
  - Stimulus: waitrequest held high 5 cycles.
  - Response: flash_mem_read and address stable for all 5 cycles; exactly one read accepted; no duplicate data.
- Backward wrap:
  - Stimulus: key 8'h32 at address START_ADDR, word 32'h1234_5678.
  - Response: getdata 1234 then 5678; next request address = END_ADDR (23'h07FFFF).
- Restart:
  - Stimulus: key 8'h2D held 100 cycles while at addr 0x100, forward.
  - Response: next request at START_ADDR; subsequent request at START_ADDR+1, i.e. a single restart only.
- Spurious confirm:
  - Stimulus: confirm_pass pulses during REQ/WAIT_DATA.
  - Response: ignored; first sample still presented after readdatavalid; no address skip.
- Reset mid-operation:
  - Stimulus: rstn = 1 during WAIT_DATA at addr 0x20.
  - Response: next cycle flash_mem_read = 0, data_valid = 0, getdata = 0, address = START_ADDR; a late readdatavalid is not captured.

Source files
------------

// File: rtl/flash_sample_reader.sv
`default_nettype none
// ============================================================================
// Module      : flash_sample_reader
// Description : Producer side of the flash-to-audio sample hand-off. Reads
//               32-bit words from an Avalon-MM flash port, presents them as
//               two 16-bit samples one at a time, and advances when the
//               consumer confirms. PS/2 keys select forward/backward play
//               and restart.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_sample_reader #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clock50,
    input  logic              rstn,
    input  logic [7:0]        key_control,
    input  logic              confirm_pass,
    output logic [15:0]       getdata,
    output logic              data_valid,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid
);

    localparam logic [2:0] S_REQ       = 3'd0;
    localparam logic [2:0] S_WAIT_DATA = 3'd1;
    localparam logic [2:0] S_FIRST     = 3'd2;
    localparam logic [2:0] S_SECOND    = 3'd3;
    localparam logic [2:0] S_ADVANCE   = 3'd4;

    localparam logic [7:0] c_KEY_FWD     = 8'h2B;
    localparam logic [7:0] c_KEY_BWD     = 8'h32;
    localparam logic [7:0] c_KEY_RESTART = 8'h2D;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic              r_dir;          // 1 = forward, 0 = backward
    logic              r_restart;
    logic [7:0]        r_key_prev;
    logic [31:0]       r_word;
    logic              r_word_dir;     // direction in force when r_word was captured
    logic [15:0]       r_getdata;
    logic              r_valid;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;

    logic [2:0]        w_state_d;
    logic              w_dir_d;
    logic              w_restart_d;
    logic [31:0]       w_word_d;
    logic              w_word_dir_d;
    logic [15:0]       w_getdata_d;
    logic              w_valid_d;
    logic              w_read_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic              w_restart_edge;
    logic [ADDR_W-1:0] w_addr_fwd;
    logic [ADDR_W-1:0] w_addr_bwd;

    // Next-state, next-output and address-step computation
    always_comb begin
        w_state_d    = r_state;
        w_dir_d      = r_dir;
        w_restart_d  = r_restart;
        w_word_d     = r_word;
        w_word_dir_d = r_word_dir;
        w_getdata_d  = r_getdata;
        w_valid_d    = r_valid;
        w_read_d     = r_read;
        w_addr_d     = r_addr;

        // Region-bounded stepping; wrap only at the region ends
        w_addr_fwd = (r_addr == END_ADDR)   ? START_ADDR : r_addr + c_ADDR_ONE;
        w_addr_bwd = (r_addr == START_ADDR) ? END_ADDR   : r_addr - c_ADDR_ONE;

        // Restart is edge-triggered so a held R key restarts only once
        w_restart_edge = (key_control == c_KEY_RESTART) && (r_key_prev != c_KEY_RESTART);

        if (key_control == c_KEY_FWD) begin
            w_dir_d = 1'b1;
        end else if (key_control == c_KEY_BWD) begin
            w_dir_d = 1'b0;
        end

        if (w_restart_edge) begin
            w_restart_d = 1'b1;
        end

        case (r_state)
            S_REQ: begin
                if (r_read && !flash_mem_waitrequest) begin
                    w_read_d  = 1'b0;
                    w_state_d = S_WAIT_DATA;
                end else begin
                    w_read_d  = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    w_word_d     = flash_mem_readdata;
                    w_word_dir_d = r_dir;
                    w_getdata_d  = r_dir ? flash_mem_readdata[15:0] : flash_mem_readdata[31:16];
                    w_valid_d    = 1'b1;
                    w_state_d    = S_FIRST;
                end
            end
            S_FIRST: begin
                if (confirm_pass) begin
                    // Second half follows the order fixed at capture time
                    w_getdata_d = r_word_dir ? r_word[31:16] : r_word[15:0];
                    w_state_d   = S_SECOND;
                end
            end
            S_SECOND: begin
                if (confirm_pass) begin
                    w_valid_d = 1'b0;
                    w_state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (r_restart) begin
                    w_addr_d = r_dir ? START_ADDR : END_ADDR;
                end else if (r_dir) begin
                    w_addr_d = w_addr_fwd;
                end else begin
                    w_addr_d = w_addr_bwd;
                end
                // A fresh R press landing in this very cycle is kept
                w_restart_d = w_restart_edge;
                w_state_d   = S_REQ;
            end
            default: begin
                w_state_d = S_REQ;
                w_read_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous reset overrides everything
    always_ff @(posedge clock50) begin
        if (rstn) begin
            r_state    <= S_REQ;
            r_dir      <= 1'b1;
            r_restart  <= 1'b0;
            r_key_prev <= 8'h00;
            r_word     <= 32'h0;
            r_word_dir <= 1'b1;
            r_getdata  <= 16'h0;
            r_valid    <= 1'b0;
            r_read     <= 1'b0;
            r_addr     <= START_ADDR;
        end else begin
            r_state    <= w_state_d;
            r_dir      <= w_dir_d;
            r_restart  <= w_restart_d;
            r_key_prev <= key_control;
            r_word     <= w_word_d;
            r_word_dir <= w_word_dir_d;
            r_getdata  <= w_getdata_d;
            r_valid    <= w_valid_d;
            r_read     <= w_read_d;
            r_addr     <= w_addr_d;
        end
    end

    assign getdata              = r_getdata;
    assign data_valid           = r_valid;
    assign flash_mem_read       = r_read;
    assign flash_mem_address    = r_addr;
    assign flash_mem_byteenable = 4'hF;

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_sample_reader
// Description : Self-checking bench for flash_sample_reader with randomized
//               flash stalls, latencies, spurious confirms and key presses,
//               compared against a word-level playback model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_sample_reader;

    localparam int          ADDR_W     = 23;
    localparam logic [22:0] START_ADDR = 23'h000000;
    localparam logic [22:0] END_ADDR   = 23'h07FFFF;
    localparam logic [7:0]  KEY_F      = 8'h2B;
    localparam logic [7:0]  KEY_B      = 8'h32;
    localparam logic [7:0]  KEY_R      = 8'h2D;
    localparam logic [7:0]  KEY_OTHER  = 8'h1C;

    logic              clk = 1'b0;
    logic              rstn;
    logic [7:0]        key_control;
    logic              confirm_pass;
    logic [15:0]       getdata;
    logic              data_valid;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    int n_checks = 0;
    int n_errors = 0;

    // Playback model: current word address, direction, pending restart, last key
    logic [22:0] m_addr;
    logic        m_dir;
    logic        m_restart;
    logic [7:0]  m_key_prev;

    flash_sample_reader #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_dut (
        .clock50                 (clk),
        .rstn                    (rstn),
        .key_control             (key_control),
        .confirm_pass            (confirm_pass),
        .getdata                 (getdata),
        .data_valid              (data_valid),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [22:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hBBBBAAAA;
    endfunction

    task automatic apply_key(input logic [7:0] k);
        key_control = k;
        if (k == KEY_F) m_dir = 1'b1;
        else if (k == KEY_B) m_dir = 1'b0;
        else if (k == KEY_R && m_key_prev != KEY_R) m_restart = 1'b1;
        m_key_prev = k;
    endtask

    task automatic model_reset();
        m_addr     = START_ADDR;
        m_dir      = 1'b1;
        m_restart  = 1'b0;
        m_key_prev = 8'h00;
    endtask

    // Wait for a read request (bounded), stall it randomly, then accept it
    task automatic request_phase();
        int          n;
        logic [22:0] held;
        n = 0;
        while (flash_mem_read !== 1'b1 && n < 20) begin
            confirm_pass = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (flash_mem_read !== 1'b1) begin
            check_eq("read_timeout", 32'(flash_mem_read), 32'h1);
            $fatal(1, "read request never appeared");
        end
        held = flash_mem_address;
        check_eq("req_addr", 32'(held), 32'(m_addr));
        repeat ($urandom_range(0, 5)) begin
            confirm_pass = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("stall_read", 32'(flash_mem_read), 32'h1);
            check_eq("stall_addr", 32'(flash_mem_address), 32'(held));
        end
        flash_mem_waitrequest = 1'b0;
        confirm_pass = 1'($urandom_range(0, 1));
        @(negedge clk);
        flash_mem_waitrequest = 1'b1;
        check_eq("read_drop", 32'(flash_mem_read), 32'h0);
    endtask

    // One complete word: request, data return, two confirmed samples
    task automatic do_word(input int key_act);
        logic [31:0] w;
        logic [15:0] s0;
        logic [15:0] s1;
        request_phase();
        repeat ($urandom_range(0, 4)) begin
            confirm_pass = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("early_valid", 32'(data_valid), 32'h0);
        end
        w  = mem_word(m_addr);
        s0 = m_dir ? w[15:0]  : w[31:16];
        s1 = m_dir ? w[31:16] : w[15:0];
        confirm_pass            = 1'b0;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = w;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = $urandom;
        check_eq("valid_first", 32'(data_valid), 32'h1);
        check_eq("sample0", 32'(getdata), 32'(s0));
        case (key_act)
            1: apply_key(KEY_F);
            2: apply_key(KEY_B);
            3: apply_key(KEY_R);
            4: apply_key(KEY_OTHER);
            default: ;
        endcase
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check_eq("hold0", 32'(getdata), 32'(s0));
        end
        confirm_pass = 1'b1;
        @(negedge clk);
        confirm_pass = 1'b0;
        check_eq("sample1", 32'(getdata), 32'(s1));
        check_eq("valid_second", 32'(data_valid), 32'h1);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check_eq("hold1", 32'(getdata), 32'(s1));
        end
        confirm_pass = 1'b1;
        @(negedge clk);
        confirm_pass = 1'b0;
        check_eq("valid_gap", 32'(data_valid), 32'h0);
        // Next word address from the playback rules
        if (m_restart) m_addr = m_dir ? START_ADDR : END_ADDR;
        else if (m_dir) m_addr = (m_addr == END_ADDR) ? START_ADDR : m_addr + 23'd1;
        else m_addr = (m_addr == START_ADDR) ? END_ADDR : m_addr - 23'd1;
        m_restart = 1'b0;
    endtask

    initial begin
        int plan [8];
        plan = '{0, 0, 2, 0, 0, 1, 3, 0};

        rstn                    = 1'b1;
        key_control             = 8'h00;
        confirm_pass            = 1'b0;
        flash_mem_waitrequest   = 1'b1;
        flash_mem_readdata      = 32'h0;
        flash_mem_readdatavalid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_getdata", 32'(getdata), 32'h0);
        check_eq("rst_valid", 32'(data_valid), 32'h0);
        check_eq("rst_read", 32'(flash_mem_read), 32'h0);
        check_eq("rst_addr", 32'(flash_mem_address), 32'(START_ADDR));
        check_eq("byteenable", 32'(flash_mem_byteenable), 32'hF);
        rstn = 1'b0;

        // Directed: forward, backward wrap at START, forward wrap at END,
        // restart, then held R giving a single restart only
        for (int i = 0; i < 8; i++) do_word(plan[i]);

        // Randomized playback
        for (int i = 0; i < 40; i++) do_word(int'($urandom_range(0, 4)));

        // Reset in the middle of a read, with readdatavalid during and just after reset
        apply_key(8'h00);
        do_word(0);
        request_phase();
        rstn                    = 1'b1;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("mid_rst_read", 32'(flash_mem_read), 32'h0);
        check_eq("mid_rst_valid", 32'(data_valid), 32'h0);
        check_eq("mid_rst_getdata", 32'(getdata), 32'h0);
        check_eq("mid_rst_addr", 32'(flash_mem_address), 32'(START_ADDR));
        rstn = 1'b0;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        check_eq("late_rdv_valid", 32'(data_valid), 32'h0);
        check_eq("late_rdv_getdata", 32'(getdata), 32'h0);
        model_reset();
        do_word(0);
        do_word(2);
        do_word(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
